apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer.sv | 147 ++++++++++++++
 tb/tb_apb_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB completer wrapping a 32-bit down-counting timer with auto-reload and a registered level irq.
// Build option: define APB_TIMER_WAIT_STATE_EN to add one wait state to every transfer.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | setup phase observed, waiting for PENABLE
// ACCESS | access phase; PREADY raised (after the optional wait state)
`timescale 1ns/1ps
module apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int NBYTES = (DATA_WIDTH / 8 < 4) ? DATA_WIDTH / 8 : 4;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            ctrl;
    logic [DATA_WIDTH-1:0] load;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] load_merged;
    logic                  exp_flag;
    logic                  ready;
    logic                  err;
    logic                  commit;
    logic                  wr_ctrl;
    logic                  wr_load;
    logic                  wr_stat;
    logic                  expire;
    logic [1:0]            reg_sel;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
            SETUP: begin
                if (PSEL && PENABLE)
                    state_nxt = ACCESS;
                else if (!PSEL)
                    state_nxt = IDLE;
            end
            ACCESS:  if (ready) state_nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef APB_TIMER_WAIT_STATE_EN
    logic waited;

    always_ff @(posedge PCLK) begin
        if (PRESET)
            waited <= 1'b0;
        else
            waited <= (state == ACCESS) && !waited;
    end

    assign ready = !PRESET && (state == ACCESS) && waited;
`else
    assign ready = !PRESET && (state == ACCESS);
`endif

    assign reg_sel = PADDR[3:2];
    assign err     = (PADDR[ADDR_WIDTH-1:4] != '0) || (PADDR[1:0] != 2'b00)
                   || (PWRITE && reg_sel == 2'd2);

    always_comb begin
        PREADY  = ready;
        PSLVERR = ready && err;
        PRDATA  = '0;
        if (ready && !err) begin
            case (reg_sel)
                2'd0:    PRDATA[2:0] = ctrl;
                2'd1:    PRDATA      = load;
                2'd2:    PRDATA      = value;
                default: PRDATA[0]   = exp_flag;
            endcase
        end
    end

    assign commit  = ready && !err && PWRITE;
    assign wr_ctrl = commit && (reg_sel == 2'd0) && PSTRB[0];
    assign wr_load = commit && (reg_sel == 2'd1);
    assign wr_stat = commit && (reg_sel == 2'd3) && PSTRB[0] && PWDATA[0];
    assign expire  = ctrl[0] && (value == DATA_WIDTH'(1));

    always_comb begin
        load_merged = load;
        for (int b = 0; b < NBYTES; b++)
            if (PSTRB[b]) load_merged[8*b +: 8] = PWDATA[8*b +: 8];
    end

    // Bus writes beat timer activity on CTRL and VALUE; expiry beats the STATUS clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl     <= '0;
            load     <= '0;
            value    <= '0;
            exp_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= PWDATA[2:0];
            else if (expire && !ctrl[1])
                ctrl[0] <= 1'b0;

            if (wr_load)
                load <= load_merged;

            if (wr_load)
                value <= load_merged;
            else if (expire)
                value <= ctrl[1] ? load : '0;
            else if (ctrl[0] && value != '0)
                value <= value - DATA_WIDTH'(1);

            if (expire)
                exp_flag <= 1'b1;
            else if (wr_stat)
                exp_flag <= 1'b0;

            irq <= exp_flag && ctrl[2];
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed scenarios plus randomized traffic against a
// cycle-stepped reference model of the register/timer rules.
`timescale 1ns/1ps
module tb_apb_timer;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB_TIMER_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    apb_timer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // reference model state
    logic [2:0]  m_ctrl  = '0;
    logic [31:0] m_load  = '0;
    logic [31:0] m_value = '0;
    logic        m_exp   = 1'b0;
    logic        m_irq   = 1'b0;
    logic        p_wr    = 1'b0;
    logic [31:0] p_addr  = '0;
    logic [31:0] p_data  = '0;
    logic [3:0]  p_strb  = '0;

    // results of the last transfer
    logic [31:0] rd, xrd;
    logic        er, xer;
    int          w;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic model_err(input logic wr, input logic [31:0] addr);
        return (addr >= 32'd16) || (addr % 4 != 0) || (wr && addr == 32'd8);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (addr)
            32'd0:   return {29'd0, m_ctrl};
            32'd4:   return m_load;
            32'd8:   return m_value;
            32'd12:  return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0]  c;
        logic [31:0] l, v, merged;
        logic        e, expire;
        if (PRESET) begin
            m_ctrl = '0; m_load = '0; m_value = '0; m_exp = 1'b0; m_irq = 1'b0; p_wr = 1'b0;
            return;
        end
        c = m_ctrl; l = m_load; e = m_exp;
        v = (m_ctrl[0] && m_value != 0) ? m_value - 1 : m_value;
        expire = m_ctrl[0] && m_value == 1;
        if (expire) begin
            e = 1'b1;
            if (m_ctrl[1]) v = m_load;
            else           c[0] = 1'b0;
        end
        if (p_wr) begin
            merged = merge((p_addr == 0) ? {29'd0, m_ctrl} : m_load, p_data, p_strb);
            case (p_addr)
                32'd0:  if (p_strb[0]) c = merged[2:0];
                32'd4:  begin l = merged; v = merged; end
                32'd12: if (p_strb[0] && p_data[0] && !expire) e = 1'b0;
                default: ;
            endcase
            p_wr = 1'b0;
        end
        m_irq   = m_exp & m_ctrl[2];
        m_ctrl  = c;
        m_load  = l;
        m_value = v;
        m_exp   = e;
    endtask

    task automatic cyc();
        @(posedge PCLK);
        model_step();
        #1;
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        cyc();
        PENABLE = 1'b1;
        w = 0;
        do begin
            cyc();
            w++;
        end while (PREADY !== 1'b1 && w < 8);
        rd  = PRDATA;
        er  = PSLVERR;
        xrd = model_read(addr);
        xer = model_err(wr, addr);
        if (wr && !xer) begin
            p_wr = 1'b1; p_addr = addr; p_data = data; p_strb = strb;
        end
        cyc();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (3) cyc();
        checks++; if (PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
        checks++; if (PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", PSLVERR); end
        checks++; if (PRDATA !== 32'd0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        PRESET = 1'b0;
        for (int a = 0; a < 16; a += 4) begin
            apb(1'b0, a, 32'd0, 4'hF);
            checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_reg%0h got=%h exp=0", a, rd); end
            checks++; if (w !== 1 + WS) begin failures++; $display("FAIL reset_latency got=%0d exp=%0d", w, 1 + WS); end
        end
    endtask

    task automatic test_oneshot();
        apb(1'b1, 32'd4, 32'd5, 4'hF);
        apb(1'b1, 32'd0, 32'd1, 4'hF);
        apb(1'b0, 32'd8, 32'd0, 4'hF);
        checks++; if (rd !== 32'(3 - WS)) begin failures++; $display("FAIL oneshot_first got=%0d exp=%0d", rd, 3 - WS); end
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 1)) cyc();
            apb(1'b0, 32'd8, 32'd0, 4'hF);
            checks++; if (rd !== xrd) begin failures++; $display("FAIL oneshot_value got=%0d exp=%0d", rd, xrd); end
        end
        apb(1'b0, 32'd8, 32'd0, 4'hF);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL oneshot_zero got=%0d exp=0", rd); end
        apb(1'b0, 32'd0, 32'd0, 4'hF);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL oneshot_en_clr got=%h exp=0", rd); end
        apb(1'b0, 32'd12, 32'd0, 4'hF);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL oneshot_exp got=%h exp=1", rd); end
    endtask

    task automatic test_auto();
        int k;
        apb(1'b1, 32'd12, 32'd1, 4'hF);
        apb(1'b1, 32'd4, 32'd3, 4'hF);
        apb(1'b1, 32'd0, 32'd7, 4'hF);
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        checks++; if (k !== 4) begin failures++; $display("FAIL auto_irq_latency got=%0d exp=4", k); end
        apb(1'b0, 32'd8, 32'd0, 4'hF);
        checks++; if (rd !== xrd || rd == 32'd0) begin failures++; $display("FAIL auto_wrap got=%0d exp=%0d", rd, xrd); end
        apb(1'b0, 32'd12, 32'd0, 4'hF);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL auto_exp got=%h exp=1", rd); end
        apb(1'b1, 32'd0, 32'd0, 4'hF);
        apb(1'b1, 32'd12, 32'd1, 4'hF);
    endtask

    task automatic test_w1c_collision();
        apb(1'b1, 32'd4, 32'(3 + WS), 4'hF);
        apb(1'b1, 32'd0, 32'd5, 4'hF);
        apb(1'b1, 32'd12, 32'd1, 4'hF);
        apb(1'b0, 32'd12, 32'd0, 4'hF);
        checks++; if (rd !== 32'd1 || xrd !== 32'd1) begin failures++; $display("FAIL w1c_collide got=%h exp=1", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_set got=%b exp=1", irq); end
        apb(1'b1, 32'd12, 32'd1, 4'hF);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_lag got=%b exp=1", irq); end
        cyc();
        checks++; if (irq !== 1'b0 || m_irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_clr got=%b exp=0", irq); end
        apb(1'b0, 32'd12, 32'd0, 4'hF);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL w1c_exp_clr got=%h exp=0", rd); end
    endtask

    task automatic test_strobe();
        apb(1'b1, 32'd0, 32'd0, 4'hF);
        apb(1'b1, 32'd4, 32'd0, 4'hF);
        apb(1'b1, 32'd4, 32'hAABBCCDD, 4'b0101);
        apb(1'b0, 32'd4, 32'd0, 4'hF);
        checks++; if (rd !== 32'h00BB00DD) begin failures++; $display("FAIL strobe_load got=%h exp=00bb00dd", rd); end
        apb(1'b0, 32'd8, 32'd0, 4'hF);
        checks++; if (rd !== xrd) begin failures++; $display("FAIL strobe_value got=%h exp=%h", rd, xrd); end
    endtask

    task automatic test_errors();
        apb(1'b1, 32'd8, $urandom, 4'hF);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wr_value got=%b exp=1", er); end
        checks++; if (w !== 1 + WS) begin failures++; $display("FAIL err_latency got=%0d exp=%0d", w, 1 + WS); end
        apb(1'b0, 32'd8, 32'd0, 4'hF);
        checks++; if (rd !== 32'h00BB00DD) begin failures++; $display("FAIL err_value_kept got=%h exp=00bb00dd", rd); end
        apb(1'b0, 32'h10, 32'd0, 4'hF);
        checks++; if (er !== 1'b1 || w !== 1 + WS) begin failures++; $display("FAIL err_rd_oob got=%b/%0d exp=1/%0d", er, w, 1 + WS); end
        apb(1'b1, 32'h14, 32'd7, 4'hF);
        apb(1'b1, 32'h1, 32'd7, 4'hF);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_misalign got=%b exp=1", er); end
        apb(1'b0, 32'd0, 32'd0, 4'hF);
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL err_ctrl_kept got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid();
        apb(1'b1, 32'd4, 32'd9, 4'hF);
        apb(1'b1, 32'd0, 32'd6, 4'hF);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 32'd1; PSTRB = 4'hF;
        cyc();
        PENABLE = 1'b1;
        cyc();
        PRESET = 1'b1;
        #1;
        checks++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b%b exp=00", PREADY, PSLVERR); end
        checks++; if (PRDATA !== 32'd0) begin failures++; $display("FAIL rstmid_prdata got=%h exp=0", PRDATA); end
        cyc();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        for (int a = 0; a < 16; a += 4) begin
            apb(1'b0, a, 32'd0, 4'hF);
            checks++; if (rd !== 32'd0 || w !== 1 + WS) begin failures++; $display("FAIL rstmid_reg%0h got=%h/%0d exp=0/%0d", a, rd, w, 1 + WS); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd2, 32'h100};
        logic [31:0] a, d;
        logic        wr;
        logic [3:0]  s;
        for (int i = 0; i < 150; i++) begin
            a  = addrs[$urandom_range(0, 6)];
            wr = 1'($urandom_range(0, 1));
            if (a == 32'd0)      d = $urandom_range(0, 7);
            else if (a == 32'd4) d = $urandom_range(0, 10);
            else                 d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            apb(wr, a, d, s);
            checks++; if (w !== 1 + WS) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, w, 1 + WS); end
            checks++; if (er !== xer) begin failures++; $display("FAIL rand_err i=%0d addr=%h got=%b exp=%b", i, a, er, xer); end
            if (!wr && !xer) begin
                checks++; if (rd !== xrd) begin failures++; $display("FAIL rand_rdata i=%0d addr=%h got=%h exp=%h", i, a, rd, xrd); end
            end
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_irq); end
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        test_reset();
        test_oneshot();
        test_auto();
        test_w1c_collision();
        test_strobe();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
